// File: rtl/fib_stream_checker.sv
// Receive-side checker for a stalled Fibonacci byte stream.
// Shadows the generator, flags mismatches and relocks from two advanced terms.
module fib_stream_checker #(
  parameter int unsigned     WIDTH  = 8,
  parameter int unsigned     CNT_W  = 16,
  parameter logic [WIDTH-1:0] SEED_A = '0,
  parameter logic [WIDTH-1:0] SEED_B = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic [WIDTH-1:0] data,
  input  logic             clr,
  output logic             locked,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] term_count
);

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    RESYNC1 = 2'd1,
    RESYNC2 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_ea;
  logic [WIDTH-1:0] r_eb;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] w_ea_n;
  logic [WIDTH-1:0] w_eb_n;
  logic [WIDTH-1:0] w_x_n;
  logic [WIDTH-1:0] w_exp;
  logic             r_locked;
  logic             w_locked_n;
  logic             r_mismatch;
  logic             w_mis_n;
  logic             r_sticky;
  logic             w_sticky_n;
  logic             w_err_inc;
  logic             w_term_inc;
  logic [CNT_W-1:0] r_err;
  logic [CNT_W-1:0] r_term;
  logic [CNT_W-1:0] w_err_n;
  logic [CNT_W-1:0] w_term_n;

  assign w_exp = adv ? r_eb : r_ea;

  always_comb begin
    w_state_n  = r_state;
    w_ea_n     = r_ea;
    w_eb_n     = r_eb;
    w_x_n      = r_x;
    w_locked_n = r_locked;
    w_mis_n    = 1'b0;
    w_err_inc  = 1'b0;
    w_term_inc = 1'b0;
    unique case (r_state)
      LOCKED: begin
        if (data == w_exp) begin
          if (adv) begin
            w_ea_n     = r_eb;
            w_eb_n     = r_ea + r_eb;
            w_term_inc = 1'b1;
          end
        end else begin
          w_mis_n    = 1'b1;
          w_err_inc  = 1'b1;
          w_locked_n = 1'b0;
          w_state_n  = RESYNC1;
        end
      end
      RESYNC1: begin
        if (adv) begin
          w_x_n     = data;
          w_state_n = RESYNC2;
        end
      end
      RESYNC2: begin
        // Relock: the next generator state is (y, x+y).
        if (adv) begin
          w_ea_n     = data;
          w_eb_n     = r_x + data;
          w_locked_n = 1'b1;
          w_state_n  = LOCKED;
        end
      end
      default: begin
        w_state_n = LOCKED;
      end
    endcase
  end

  // clr wins over any increment in the same cycle.
  always_comb begin
    w_err_n    = r_err;
    w_term_n   = r_term;
    w_sticky_n = r_sticky | w_mis_n;
    if (w_err_inc && (r_err != {CNT_W{1'b1}}))
      w_err_n = r_err + 1'b1;
    if (w_term_inc && (r_term != {CNT_W{1'b1}}))
      w_term_n = r_term + 1'b1;
    if (clr) begin
      w_err_n    = '0;
      w_term_n   = '0;
      w_sticky_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= LOCKED;
      r_ea       <= SEED_A;
      r_eb       <= SEED_B;
      r_x        <= '0;
      r_locked   <= 1'b1;
      r_mismatch <= 1'b0;
      r_sticky   <= 1'b0;
      r_err      <= '0;
      r_term     <= '0;
    end else begin
      r_state    <= w_state_n;
      r_ea       <= w_ea_n;
      r_eb       <= w_eb_n;
      r_x        <= w_x_n;
      r_locked   <= w_locked_n;
      r_mismatch <= w_mis_n;
      r_sticky   <= w_sticky_n;
      r_err      <= w_err_n;
      r_term     <= w_term_n;
    end
  end

  assign locked     = r_locked;
  assign mismatch   = r_mismatch;
  assign err_sticky = r_sticky;
  assign err_count  = r_err;
  assign term_count = r_term;

endmodule

// File: tb/tb_fib_stream_checker.sv
// Directed testbench for fib_stream_checker.
// A second narrow-counter instance exercises saturation quickly.
module tb_fib_stream_checker;

  logic        clk;
  logic        rst;
  logic        adv;
  logic [7:0]  data;
  logic        clr;
  logic        locked;
  logic        mismatch;
  logic        err_sticky;
  logic [15:0] err_count;
  logic [15:0] term_count;

  logic        s_adv;
  logic [7:0]  s_data;
  logic        s_clr;
  logic        s_locked;
  logic        s_mismatch;
  logic        s_sticky;
  logic [2:0]  s_err;
  logic [2:0]  s_term;

  int n_tests = 0;
  int n_fail  = 0;

  fib_stream_checker u_dut (
    .clk        (clk),
    .rst        (rst),
    .adv        (adv),
    .data       (data),
    .clr        (clr),
    .locked     (locked),
    .mismatch   (mismatch),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .term_count (term_count)
  );

  fib_stream_checker #(.CNT_W(3)) u_sat (
    .clk        (clk),
    .rst        (rst),
    .adv        (s_adv),
    .data       (s_data),
    .clr        (s_clr),
    .locked     (s_locked),
    .mismatch   (s_mismatch),
    .err_sticky (s_sticky),
    .err_count  (s_err),
    .term_count (s_term)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic a, input logic [7:0] d, input logic c);
    adv  = a;
    data = d;
    clr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic sstep(input logic a, input logic [7:0] d, input logic c);
    s_adv  = a;
    s_data = d;
    s_clr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (locked !== 1'b1 || mismatch !== 1'b0 || err_sticky !== 1'b0 ||
        err_count !== 16'd0 || term_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset: lk=%b mm=%b st=%b err=%0d term=%0d exp 1 0 0 0 0",
               locked, mismatch, err_sticky, err_count, term_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_lock;
    logic [7:0] seq [14];
    int bad;
    seq = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
            8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121};
    bad = 0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(1'b1, seq[i], 1'b0);
      if (mismatch !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL lock_mismatch: %0d pulses, exp 0", bad);
    end
    n_tests++;
    if (locked !== 1'b1 || term_count !== 16'd14 || err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL lock_counts: lk=%b term=%0d err=%0d exp 1 14 0",
               locked, term_count, err_count);
    end
  endtask

  task automatic test_stall;
    int bad;
    bad = 0;
    do_reset();
    step(1'b1, 8'd1, 1'b0);
    step(1'b1, 8'd1, 1'b0);
    step(1'b1, 8'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'd2, 1'b0);
      if (mismatch !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0 || term_count !== 16'd3) begin
      n_fail++;
      $display("FAIL stall_hold: pulses=%0d term=%0d exp 0 3", bad, term_count);
    end
    step(1'b0, 8'd3, 1'b0);
    n_tests++;
    if (mismatch !== 1'b1 || locked !== 1'b0 || err_count !== 16'd1 ||
        err_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_mismatch: mm=%b lk=%b err=%0d st=%b exp 1 0 1 1",
               mismatch, locked, err_count, err_sticky);
    end
  endtask

  task automatic test_resync;
    step(1'b0, 8'd99, 1'b0);
    n_tests++;
    if (mismatch !== 1'b0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL resync_pulse: mm=%b lk=%b exp 0 0", mismatch, locked);
    end
    step(1'b1, 8'd8, 1'b0);
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL resync_first: lk=%b exp 0", locked);
    end
    step(1'b1, 8'd13, 1'b0);
    n_tests++;
    if (locked !== 1'b1 || mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL resync_lock: lk=%b mm=%b exp 1 0", locked, mismatch);
    end
    step(1'b1, 8'd21, 1'b0);
    step(1'b1, 8'd34, 1'b0);
    n_tests++;
    if (mismatch !== 1'b0 || term_count !== 16'd5 || err_count !== 16'd1) begin
      n_fail++;
      $display("FAIL resync_follow: mm=%b term=%0d err=%0d exp 0 5 1",
               mismatch, term_count, err_count);
    end
  endtask

  task automatic test_wrap;
    int bad;
    bad = 0;
    step(1'b1, 8'd0, 1'b0);
    n_tests++;
    if (mismatch !== 1'b1 || err_count !== 16'd2) begin
      n_fail++;
      $display("FAIL wrap_break: mm=%b err=%0d exp 1 2", mismatch, err_count);
    end
    step(1'b1, 8'd233, 1'b0);
    step(1'b1, 8'd121, 1'b0);
    step(1'b1, 8'd98, 1'b0);
    if (mismatch !== 1'b0) bad++;
    step(1'b1, 8'd219, 1'b0);
    if (mismatch !== 1'b0) bad++;
    n_tests++;
    if (bad != 0 || locked !== 1'b1 || term_count !== 16'd7) begin
      n_fail++;
      $display("FAIL wrap_terms: pulses=%0d lk=%b term=%0d exp 0 1 7",
               bad, locked, term_count);
    end
  endtask

  task automatic test_clr;
    step(1'b1, 8'd0, 1'b1);
    n_tests++;
    if (mismatch !== 1'b1 || err_count !== 16'd0 || err_sticky !== 1'b0 ||
        term_count !== 16'd0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_priority: mm=%b err=%0d st=%b term=%0d lk=%b exp 1 0 0 0 0",
               mismatch, err_count, err_sticky, term_count, locked);
    end
    clr = 1'b0;
  endtask

  task automatic test_async_reset;
    step(1'b1, 8'd10, 1'b0);
    step(1'b1, 8'd20, 1'b0);
    step(1'b1, 8'd30, 1'b0);
    step(1'b1, 8'd0, 1'b0);
    n_tests++;
    if (mismatch !== 1'b1 || err_count !== 16'd1 || term_count !== 16'd1) begin
      n_fail++;
      $display("FAIL arst_setup: mm=%b err=%0d term=%0d exp 1 1 1",
               mismatch, err_count, term_count);
    end
    step(1'b1, 8'd7, 1'b0);
    adv = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (locked !== 1'b1 || err_count !== 16'd0 || term_count !== 16'd0 ||
        err_sticky !== 1'b0 || mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_now: lk=%b err=%0d term=%0d st=%b mm=%b exp 1 0 0 0 0",
               locked, err_count, term_count, err_sticky, mismatch);
    end
    #1;
    rst = 1'b0;
    step(1'b1, 8'd1, 1'b0);
    n_tests++;
    if (mismatch !== 1'b0 || term_count !== 16'd1) begin
      n_fail++;
      $display("FAIL arst_after: mm=%b term=%0d exp 0 1", mismatch, term_count);
    end
  endtask

  task automatic test_saturation;
    logic [7:0] terms [9];
    terms = '{8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55, 8'd89};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      sstep(1'b1, 8'd255, 1'b0);
      sstep(1'b1, 8'd1, 1'b0);
      sstep(1'b1, 8'd1, 1'b0);
    end
    n_tests++;
    if (s_err !== 3'd7) begin
      n_fail++;
      $display("FAIL sat_reach: err=%0d exp 7", s_err);
    end
    sstep(1'b1, 8'd255, 1'b0);
    n_tests++;
    if (s_err !== 3'd7 || s_mismatch !== 1'b1 || s_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_err_hold: err=%0d mm=%b st=%b exp 7 1 1",
               s_err, s_mismatch, s_sticky);
    end
    sstep(1'b1, 8'd1, 1'b0);
    sstep(1'b1, 8'd1, 1'b0);
    for (int i = 0; i < 9; i++) sstep(1'b1, terms[i], 1'b0);
    n_tests++;
    if (s_term !== 3'd7 || s_mismatch !== 1'b0 || s_err !== 3'd7) begin
      n_fail++;
      $display("FAIL sat_term_hold: term=%0d mm=%b err=%0d exp 7 0 7",
               s_term, s_mismatch, s_err);
    end
    sstep(1'b1, 8'd0, 1'b1);
    n_tests++;
    if (s_err !== 3'd0 || s_sticky !== 1'b0 || s_mismatch !== 1'b1 ||
        s_term !== 3'd0) begin
      n_fail++;
      $display("FAIL sat_clr: err=%0d st=%b mm=%b term=%0d exp 0 0 1 0",
               s_err, s_sticky, s_mismatch, s_term);
    end
    s_clr = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    adv    = 1'b0;
    data   = 8'd0;
    clr    = 1'b0;
    s_adv  = 1'b0;
    s_data = 8'd0;
    s_clr  = 1'b0;
    test_reset();
    test_lock();
    test_stall();
    test_resync();
    test_wrap();
    test_clr();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_stream_checker.md
Name: fib_stream_checker

Overview:
Receive-side checker for the stalled Fibonacci byte stream produced by the two-register sequence generator (state (a,b), seed (0,1), 1-bit advance input, 8-bit output). It sits on the generator's output and advance control. It keeps a shadow model of the generator, compares every output byte against it, and counts matches and errors. After a mismatch it relocks automatically from two consecutive advanced terms.

Parameters:
WIDTH, 8, data/term width; all sequence arithmetic is modulo 2^WIDTH
CNT_W, 16, width of the error and term counters
SEED_A, 0, reset value of shadow register a
SEED_B, 1, reset value of shadow register b

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
adv  in  1  same advance bit that drives the generator in this cycle
data  in  WIDTH  generator output byte for this cycle
clr  in  1  synchronous clear of err_sticky, err_count and term_count
locked  out  1  shadow model is synchronized (registered)
mismatch  out  1  one-cycle pulse: previous cycle's compare failed (registered)
err_sticky  out  1  set on any mismatch; cleared only by clr or rst
err_count  out  CNT_W  saturating mismatch count
term_count  out  CNT_W  saturating count of matched advanced terms while locked

Behaviour:
- Reset is asynchronous, active-high on rst; clock is clk.
- Reset values: ea=SEED_A, eb=SEED_B, state=LOCKED, locked=1, mismatch=0, err_sticky=0, err_count=0, term_count=0.
- Generator model per cycle: when adv=1, out=b and next state is (b, a+b). When adv=0, out=a and the state holds. The checker uses expected exp = adv ? eb : ea.
- Latency: all outputs are registered. The compare result for a cycle-N sample appears on mismatch/locked/counters at cycle N+1.
- State machine {LOCKED, RESYNC1, RESYNC2}:
  - LOCKED, data==exp:
    - If adv=1: ea<=eb, eb<=ea+eb (truncated to WIDTH), term_count++.
    - If adv=0: hold.
  - LOCKED, data!=exp: mismatch<=1, err_sticky<=1, err_count++, locked<=0, go to RESYNC1. Shadow registers are don't-care.
  - RESYNC1:
    - adv=0: ignored.
    - adv=1: capture x<=data, go to RESYNC2.
  - RESYNC2:
    - adv=0: ignored. No compare is made in any resync state.
    - adv=1 with data=y: ea<=y, eb<=x+y (mod 2^WIDTH), locked<=1, go to LOCKED. The next sample is compared normally.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- clr has priority over an increment in the same cycle: counters go to 0 and err_sticky to 0. The mismatch pulse and the state transition still occur.
- rst mid-resync returns the block to LOCKED with the seed values. It has the same effect as a generator reset.
- A mismatch on the first cycle after reset is counted like any other mismatch.
- No combinational path from any input to any output.
- Scoped at roughly 150–250 RTL lines.

Test Plan:
- Lock from reset: rst pulse, then adv=1 for 14 cycles with data 1,1,2,3,5,8,13,21,34,55,89,144,233,121 → mismatch never 1, locked=1, term_count=14, err_count=0.
- Stall: after the advanced terms 1,1,2 (model (2,3)), drive adv=0 data=2 for 3 cycles → no mismatch, term_count stays 3. Then adv=0 data=3 → mismatch=1 for exactly one cycle, locked=0, err_count=1, err_sticky=1.
- Resync: from RESYNC1, adv=0 data=99 (ignored), then adv=1 data=8, adv=1 data=13 → locked=1 one cycle after the second sample. Then adv=1 data=21, 34 → no mismatch, term_count +2 (term_count does not count the two resync samples).
- Wrap arithmetic: resync with 233, 121, then adv=1 data=98, 219 → no mismatch, since 354 and 219 are taken mod 256.
- Saturation/clr: force err_count to 65535 via repeated mismatches, one more mismatch → stays 65535. Assert clr in the same cycle as a mismatch → err_count=0, err_sticky=0, mismatch=1.
- Async reset mid-operation: assert rst asynchronously while in RESYNC2 → locked=1, counters 0 immediately. Next adv=1 data=1 → match.
